// File: rtl/ddr2buf_loader.sv
// ============================================================================
// Module   : ddr2buf_loader
// Purpose  : Issues strided DDR read bursts and streams the returned beats
//            sequentially into a local PE-side buffer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ddr2buf_loader #(
    parameter int DDR_W      = 512,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 8,
    parameter int BUF_DEPTH  = 256,
    parameter int ADDR_W     = $clog2(BUF_DEPTH),
    parameter int MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    output logic                  busy,
    input  logic [DDR_ADDR_W-1:0] conf_st_addr,
    input  logic [BURST_W-1:0]    conf_burst,
    input  logic [DDR_ADDR_W-1:0] conf_step,
    input  logic [BURST_W-1:0]    conf_burst_num,
    input  logic [ADDR_W-1:0]     conf_buf_base,
    output logic [DDR_ADDR_W-1:0] ddr_addr,
    output logic [BURST_W-1:0]    ddr_size,
    output logic                  ddr_addr_valid,
    input  logic                  ddr_addr_ready,
    input  logic [DDR_W-1:0]      ddr_data,
    input  logic                  ddr_valid,
    output logic                  ddr_ready,
    output logic [ADDR_W-1:0]     buf_wr_addr,
    output logic [DDR_W-1:0]      buf_wr_data,
    output logic                  buf_wr_en
);

    localparam int                 c_OUT_W   = 4;
    localparam int                 c_TOT_W   = 2 * BURST_W;
    localparam logic [c_OUT_W-1:0] c_MAX_OUT = c_OUT_W'(MAX_OUT);
    localparam logic [ADDR_W-1:0]  c_BUF_TOP = ADDR_W'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [BURST_W-1:0]      r_burst;
    logic [DDR_ADDR_W-1:0]   r_step;
    logic [BURST_W-1:0]      r_burst_num;
    logic [c_TOT_W-1:0]      r_total;
    logic [BURST_W-1:0]      r_issued;
    logic [c_OUT_W-1:0]      r_outst;
    logic [BURST_W-1:0]      r_beat;
    logic [c_TOT_W-1:0]      r_beat_cnt;
    logic [ADDR_W-1:0]       r_wr_ptr;

    logic                    w_addr_hs;
    logic                    w_beat_acc;
    logic                    w_last_beat;
    logic                    w_final;
    logic                    w_start_go;
    logic                    w_valid_nxt;
    logic [BURST_W-1:0]      w_issued_nxt;
    logic [c_OUT_W-1:0]      w_outst_nxt;
    logic [ADDR_W-1:0]       w_wr_ptr_nxt;

    assign w_addr_hs    = ddr_addr_valid & ddr_addr_ready;
    assign w_beat_acc   = ddr_valid & ddr_ready;
    assign w_last_beat  = w_beat_acc & (r_beat == r_burst - 1'b1);
    assign w_final      = w_beat_acc & (r_beat_cnt == r_total - 1'b1);
    assign w_start_go   = (conf_burst != '0) && (conf_burst_num != '0);
    assign w_issued_nxt = r_issued + BURST_W'(w_addr_hs);
    assign w_outst_nxt  = r_outst + c_OUT_W'(w_addr_hs) - c_OUT_W'(w_last_beat);
    assign w_wr_ptr_nxt = (r_wr_ptr == c_BUF_TOP) ? '0 : r_wr_ptr + 1'b1;
    // A stalled request keeps this true: issued is unchanged and outstanding can only fall.
    assign w_valid_nxt  = (w_issued_nxt < r_burst_num) && (w_outst_nxt < c_MAX_OUT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_burst        <= '0;
            r_step         <= '0;
            r_burst_num    <= '0;
            r_total        <= '0;
            r_issued       <= '0;
            r_outst        <= '0;
            r_beat         <= '0;
            r_beat_cnt     <= '0;
            r_wr_ptr       <= '0;
            done           <= 1'b0;
            busy           <= 1'b0;
            ddr_addr       <= '0;
            ddr_size       <= '0;
            ddr_addr_valid <= 1'b0;
            ddr_ready      <= 1'b0;
            buf_wr_addr    <= '0;
            buf_wr_data    <= '0;
            buf_wr_en      <= 1'b0;
        end else begin
            done      <= 1'b0;
            buf_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_burst     <= conf_burst;
                        r_step      <= conf_step;
                        r_burst_num <= conf_burst_num;
                        r_total     <= c_TOT_W'(conf_burst) * c_TOT_W'(conf_burst_num);
                        r_issued    <= '0;
                        r_outst     <= '0;
                        r_beat      <= '0;
                        r_beat_cnt  <= '0;
                        r_wr_ptr    <= conf_buf_base;
                        ddr_addr    <= conf_st_addr;
                        ddr_size    <= conf_burst;
                        busy        <= 1'b1;
                        if (w_start_go) begin
                            r_state        <= S_RUN;
                            ddr_addr_valid <= 1'b1;
                            ddr_ready      <= 1'b1;
                        end else begin
                            r_state <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    r_issued       <= w_issued_nxt;
                    r_outst        <= w_outst_nxt;
                    ddr_addr_valid <= w_valid_nxt;
                    if (w_addr_hs) begin
                        ddr_addr <= ddr_addr + r_step;
                    end
                    if (w_beat_acc) begin
                        r_beat      <= w_last_beat ? '0 : r_beat + 1'b1;
                        r_beat_cnt  <= r_beat_cnt + 1'b1;
                        buf_wr_en   <= 1'b1;
                        buf_wr_data <= ddr_data;
                        buf_wr_addr <= r_wr_ptr;
                        r_wr_ptr    <= w_wr_ptr_nxt;
                    end
                    if (w_final) begin
                        r_state        <= S_FIN;
                        ddr_ready      <= 1'b0;
                        ddr_addr_valid <= 1'b0;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr2buf_loader.sv
// ============================================================================
// Module   : tb_ddr2buf_loader
// Purpose  : Randomised scoreboard bench for ddr2buf_loader with a DDR
//            responder and a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ddr2buf_loader;

    localparam int TB_MAX = 2;

    typedef struct {
        logic [7:0]   a;
        logic [511:0] d;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         done;
    logic         busy;
    logic [31:0]  conf_st_addr;
    logic [7:0]   conf_burst;
    logic [31:0]  conf_step;
    logic [7:0]   conf_burst_num;
    logic [7:0]   conf_buf_base;
    logic [31:0]  ddr_addr;
    logic [7:0]   ddr_size;
    logic         ddr_addr_valid;
    logic         ddr_addr_ready;
    logic [511:0] ddr_data;
    logic         ddr_valid;
    logic         ddr_ready;
    logic [7:0]   buf_wr_addr;
    logic [511:0] buf_wr_data;
    logic         buf_wr_en;

    ddr2buf_loader #(.MAX_OUT(TB_MAX)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
        .conf_st_addr(conf_st_addr), .conf_burst(conf_burst), .conf_step(conf_step),
        .conf_burst_num(conf_burst_num), .conf_buf_base(conf_buf_base),
        .ddr_addr(ddr_addr), .ddr_size(ddr_size), .ddr_addr_valid(ddr_addr_valid),
        .ddr_addr_ready(ddr_addr_ready), .ddr_data(ddr_data), .ddr_valid(ddr_valid),
        .ddr_ready(ddr_ready), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .buf_wr_en(buf_wr_en)
    );

    always #5 clk = ~clk;

    // Reference model state: what the transfer should look like at transaction level
    logic [31:0] addr_exp[$];
    wr_t         wr_exp[$];
    logic [31:0] mem_q[$];
    int          m_burst, m_num, m_total;
    int          issued, beats_acc, db, hs_count, wr_seen, stall_cnt;
    bit          in_run, done_due, prev_stall;
    logic [31:0] prev_addr;
    logic [31:0] seed;
    bit          ar_rand, dv_rand, withhold;
    int          bp_left;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [511:0] beat_data(input logic [31:0] a, input int j, input logic [31:0] s);
        return {{14{s ^ (32'(j) * 32'h9E3779B9)}}, a, 32'(j)};
    endfunction

    // DDR responder: address acceptance and in-order read data return
    initial begin
        ddr_addr_ready = 1'b0;
        ddr_valid      = 1'b0;
        ddr_data       = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_left > 0 && hs_count == 1) begin
                ddr_addr_ready = 1'b0;
                bp_left--;
            end else begin
                ddr_addr_ready = ar_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (mem_q.size() > 0 && !withhold && (!dv_rand || $urandom_range(0, 3) != 0)) begin
                ddr_valid = 1'b1;
                ddr_data  = beat_data(mem_q[0], db, seed);
            end else begin
                ddr_valid = 1'b0;
                ddr_data  = {16{$urandom}};
            end
        end
    end

    // Monitor: judges the current cycle, then applies the events of the coming edge
    initial begin
        bit   fin_now;
        wr_t  w;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (rst) begin
                fin_now = in_run && (beats_acc == m_total);
                chk("busy", 512'(busy), 512'(in_run));
                chk("done", 512'(done), 512'(done_due));
                chk("addr_valid", 512'(ddr_addr_valid),
                    512'(in_run && issued < m_num && mem_q.size() < TB_MAX));
                chk("ddr_ready", 512'(ddr_ready), 512'(in_run && beats_acc < m_total));
                if (prev_stall) begin
                    chk("stall_valid_hold", 512'(ddr_addr_valid), 512'(1));
                    chk("stall_addr_hold", 512'(ddr_addr), 512'(prev_addr));
                end
                prev_stall = ddr_addr_valid && !ddr_addr_ready;
                prev_addr  = ddr_addr;
                if (prev_stall && hs_count == 1) stall_cnt++;
                if (ddr_addr_valid && ddr_addr_ready) begin
                    if (addr_exp.size() == 0) begin
                        chk("unexpected_addr", 512'(ddr_addr), 512'(0));
                        a = 32'h0;
                    end else begin
                        a = addr_exp.pop_front();
                    end
                    chk("ddr_addr", 512'(ddr_addr), 512'(a));
                    chk("ddr_size", 512'(ddr_size), 512'(m_burst));
                    mem_q.push_back(ddr_addr);
                    issued++;
                    hs_count++;
                end
                if (buf_wr_en) begin
                    if (wr_exp.size() == 0) begin
                        chk("unexpected_write", 512'(buf_wr_en), 512'(0));
                    end else begin
                        w = wr_exp.pop_front();
                        chk("buf_wr_addr", 512'(buf_wr_addr), 512'(w.a));
                        chk("buf_wr_data", buf_wr_data, w.d);
                    end
                    wr_seen++;
                end
                if (ddr_valid && ddr_ready && mem_q.size() > 0) begin
                    beats_acc++;
                    db++;
                    if (db == m_burst) begin
                        db = 0;
                        void'(mem_q.pop_front());
                    end
                end
                done_due = fin_now;
                if (fin_now) in_run = 1'b0;
            end
        end
    end

    task automatic launch(input logic [31:0] st, input logic [7:0] b, input logic [31:0] stp,
                          input logic [7:0] n, input logic [7:0] base);
        logic [31:0] a;
        @(posedge clk);
        #1;
        conf_st_addr = st; conf_burst = b; conf_step = stp;
        conf_burst_num = n; conf_buf_base = base; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        conf_st_addr = $urandom; conf_burst = 8'($urandom); conf_step = $urandom;
        conf_burst_num = 8'($urandom); conf_buf_base = 8'($urandom);
        seed = $urandom;
        m_burst = int'(b);
        m_num = (b == 0) ? 0 : int'(n);
        m_total = int'(b) * int'(n);
        issued = 0; beats_acc = 0; db = 0; hs_count = 0; wr_seen = 0; stall_cnt = 0;
        if (b != 0 && n != 0) begin
            for (int i = 0; i < int'(n); i++) begin
                a = st + stp * 32'(i);
                addr_exp.push_back(a);
                for (int j = 0; j < int'(b); j++)
                    wr_exp.push_back('{8'(int'(base) + i * int'(b) + j), beat_data(a, j, seed)});
            end
        end
        in_run = 1'b1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (cyc > 3000) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_timeout: got no done after %0d cycles", cyc);
                break;
            end
        end
        chk("addr_q_empty", 512'(addr_exp.size()), 512'(0));
        chk("wr_q_empty", 512'(wr_exp.size()), 512'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b0; start = 1'b0;
        conf_st_addr = '0; conf_burst = '0; conf_step = '0; conf_burst_num = '0; conf_buf_base = '0;
        ar_rand = 1'b0; dv_rand = 1'b0; withhold = 1'b0; bp_left = 0;
        in_run = 1'b0; done_due = 1'b0; prev_stall = 1'b0; prev_addr = '0;
        m_burst = 0; m_num = 0; m_total = 0; seed = '0;
        issued = 0; beats_acc = 0; db = 0; hs_count = 0; wr_seen = 0; stall_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 512'({done, busy, ddr_addr_valid, ddr_ready, buf_wr_en}), 512'(0));
        chk("reset_addr", 512'({ddr_addr, ddr_size, buf_wr_addr}), 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic transfer with an ignored start mid-run
        launch(32'h1000, 8'd4, 32'h40, 8'd3, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        conf_burst = 8'd2; conf_burst_num = 8'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
        chk("basic_hs_count", 512'(hs_count), 512'(3));

        // Address back-pressure on the second burst
        launch(32'h1000, 8'd4, 32'h40, 8'd3, 8'd0);
        bp_left = 5;
        wait_done(cyc);
        chk("bp_stall_cycles", 512'(stall_cnt), 512'(5));

        // Outstanding limit with data withheld
        withhold = 1'b1;
        launch(32'h2000, 8'd4, 32'h100, 8'd4, 8'd10);
        repeat (12) @(negedge clk);
        chk("outst_hs_count", 512'(hs_count), 512'(TB_MAX));
        chk("outst_valid_low", 512'(ddr_addr_valid), 512'(0));
        withhold = 1'b0;
        wait_done(cyc);

        // Buffer address wrap
        launch(32'h3000, 8'd4, 32'h40, 8'd1, 8'd254);
        wait_done(cyc);

        // Zero-size configurations
        launch(32'h4000, 8'd4, 32'h40, 8'd0, 8'd0);
        wait_done(cyc);
        chk("zero_num_done_lat", 512'(cyc), 512'(2));
        launch(32'h4000, 8'd0, 32'h40, 8'd5, 8'd0);
        wait_done(cyc);
        chk("zero_burst_done_lat", 512'(cyc), 512'(2));

        // Reset after the fifth write, then rerun
        launch(32'h1000, 8'd4, 32'h40, 8'd3, 8'd0);
        cyc = 0;
        while (wr_seen < 5 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("reset_wait_writes", 512'(wr_seen >= 5), 512'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        in_run = 1'b0; done_due = 1'b0; prev_stall = 1'b0;
        addr_exp.delete(); wr_exp.delete(); mem_q.delete();
        db = 0; issued = 0; beats_acc = 0; m_num = 0; m_total = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ctrl", 512'({done, busy, ddr_addr_valid, ddr_ready, buf_wr_en}), 512'(0));
        chk("midrst_addr", 512'({ddr_addr, ddr_size, buf_wr_addr}), 512'(0));
        chk("midrst_data", buf_wr_data, 512'(0));
        launch(32'h1000, 8'd4, 32'h40, 8'd3, 8'd0);
        wait_done(cyc);

        // Randomised transfers with random handshake timing
        ar_rand = 1'b1;
        dv_rand = 1'b1;
        for (int k = 0; k < 12; k++) begin
            launch($urandom, 8'($urandom_range(1, 6)), $urandom,
                   8'($urandom_range(1, 5)), 8'($urandom_range(0, 255)));
            wait_done(cyc);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ddr2buf_loader.md
Name: ddr2buf_loader

Overview:
- Read-side counterpart of the PE-to-DDR writeback path.
- Issues a strided sequence of DDR read bursts, accepts the returned read-data beats and writes them sequentially into a local on-chip buffer (activation/weight/bias buffer feeding the PEs).
- Sits between the DDR read channel and the PE-side buffer write port.
- Controlled by a start/done pair from the layer controller.

Parameters:
- DDR_W, 512, DDR data beat width.
- DDR_ADDR_W, 32, DDR address width.
- BURST_W, 8, width of burst-length and burst-count fields.
- BUF_DEPTH, 256, local buffer depth in DDR_W words.
- ADDR_W, bw(BUF_DEPTH), buffer address width.
- MAX_OUT, 4, maximum read bursts outstanding (address accepted, last beat not yet received); range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start  in  1  one-cycle start pulse; configuration sampled in the same cycle
- done  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after an accepted start until done
- conf_st_addr  in  DDR_ADDR_W  DDR address of the first burst
- conf_burst  in  BURST_W  beats per burst
- conf_step  in  DDR_ADDR_W  address increment between bursts
- conf_burst_num  in  BURST_W  number of bursts
- conf_buf_base  in  ADDR_W  buffer address of the first beat
- ddr_addr  out  DDR_ADDR_W  read burst address
- ddr_size  out  BURST_W  read burst length in beats (equals conf_burst)
- ddr_addr_valid  out  1  address request valid
- ddr_addr_ready  in  1  address request accepted
- ddr_data  in  DDR_W  read data beat
- ddr_valid  in  1  read data valid
- ddr_ready  out  1  read data accepted
- buf_wr_addr  out  ADDR_W  buffer write address
- buf_wr_data  out  DDR_W  buffer write data
- buf_wr_en  out  1  buffer write enable

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE.
  - All outputs 0; all counters 0.
  - Applies at any time, including mid-transfer; in-flight bursts are abandoned.
- States:
  - IDLE -> RUN on start when conf_burst!=0 and conf_burst_num!=0.
  - IDLE -> FIN on start when either field is 0; no DDR traffic.
  - RUN -> FIN when the final buffer write has been issued.
  - FIN -> IDLE unconditionally; done=1 for exactly that one cycle.
- start while not IDLE is ignored. Configuration is latched on start; later changes to the conf inputs have no effect.
- Address side (RUN only):
  - ddr_addr_valid=1 while issued bursts < conf_burst_num and outstanding < MAX_OUT.
  - First address is conf_st_addr; each address handshake (valid&&ready) adds conf_step, modulo 2^DDR_ADDR_W.
  - ddr_addr, ddr_size and ddr_addr_valid are registered and held stable while valid && !ready; valid never drops without a handshake.
  - ddr_size=conf_burst.
- Outstanding counter: +1 on an address handshake, -1 on the last beat of a burst. On a simultaneous +1 and -1 it is unchanged.
- Data side:
  - ddr_ready=1 throughout RUN (the buffer write is never back-pressured); 0 otherwise.
  - A beat is accepted on ddr_valid&&ddr_ready.
  - A beat counter wraps at conf_burst to mark the last beat of each burst.
  - Beats arriving in IDLE/FIN are not accepted and not written.
- Buffer write, latency 1:
  - The cycle after an accepted beat: buf_wr_en=1, buf_wr_data=beat, buf_wr_addr=conf_buf_base+beat_index modulo BUF_DEPTH (wraps 255->0 at default depth).
  - Otherwise buf_wr_en=0 and data/addr hold their last value.
- Termination:
  - Total beats = conf_burst*conf_burst_num, computed at 2*BURST_W width.
  - The FIN transition occurs in the cycle where the final write is driven; done is asserted the next cycle.
- busy=1 in RUN and FIN, 0 in IDLE.
- Data is assumed returned in request order; no read ID handling.

Test Plan:
- Basic transfer:
  - Stimulus: st_addr=0x1000, burst=4, step=0x40, burst_num=3, base=0; addr_ready and data_valid always high after each address.
  - Response: addresses 0x1000, 0x1040, 0x1080 with size 4; 12 writes to addresses 0..11 in order; one done pulse one cycle after the 12th write; busy low afterwards.
- Address back-pressure:
  - Stimulus: addr_ready held low for 5 cycles on the 2nd burst.
  - Response: ddr_addr_valid stays 1 with ddr_addr=0x1040 stable for all 5 cycles; no duplicate or skipped address.
- Outstanding limit:
  - Stimulus: MAX_OUT=2, burst=4, burst_num=4, data withheld.
  - Response: exactly 2 address handshakes. The 3rd ddr_addr_valid rises only after the 4th beat of burst 0 is accepted.
- Buffer wrap:
  - Stimulus: base=254, burst=4, burst_num=1.
  - Response: writes to addresses 254, 255, 0, 1.
- Zero-size and ignored start:
  - Stimulus: start with burst_num=0.
  - Response: done exactly 2 cycles later, no addr_valid or buf_wr_en. A second start issued mid-RUN is ignored (burst count unchanged).
- Reset mid-transfer:
  - Stimulus: rst=0 after the 5th write of the basic transfer.
  - Response: the next cycle all outputs are 0 and state is IDLE. A following start reruns the basic transfer correctly from address 0x1000.
